// File: rtl/ct_ifu_sfp_pkg.sv
// Shared constants, state encoding and write-data packing for the SFP entry controller.
package ct_ifu_sfp_pkg;

  localparam logic [3:0] CNT_NONE = 4'b0000;
  localparam logic [3:0] CNT_CLR  = 4'b1000;
  localparam logic [3:0] CNT_INC  = 4'b0100;
  localparam logic [3:0] CNT_SET1 = 4'b0010;
  localparam logic [3:0] CNT_DEC  = 4'b0001;

  localparam int DATA_W    = 25;
  localparam int TYPE_BIT  = 24;
  localparam int HI_PC_MSB = 23;
  localparam int HI_PC_LSB = 16;
  localparam int PC_MSB    = 15;
  localparam int PC_LSB    = 4;
  localparam int OP_MSB    = 3;
  localparam int OP_LSB    = 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sfp_state_e;

  function automatic logic [DATA_W-1:0] sfp_pack_data(
    input logic        etype,
    input logic [7:0]  hi_pc,
    input logic [11:0] pc,
    input logic [3:0]  op
  );
    logic [DATA_W-1:0] d;
    d                      = {DATA_W{1'b0}};
    d[TYPE_BIT]            = etype;
    d[HI_PC_MSB:HI_PC_LSB] = hi_pc;
    d[PC_MSB:PC_LSB]       = pc;
    d[OP_MSB:OP_LSB]       = op;
    return d;
  endfunction

endpackage

// File: rtl/ct_ifu_sfp_victim_sel.sv
// Allocation target picker: lowest invalid entry, otherwise the round-robin victim.
module ct_ifu_sfp_victim_sel #(
  parameter int ENTRY_NUM = 8,
  parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic [ENTRY_NUM-1:0] vld,
  input  logic [IDX_W-1:0]     victim_ptr,
  output logic [IDX_W-1:0]     tgt_idx,
  output logic                 replace
);
  import ct_ifu_sfp_pkg::*;

  logic [IDX_W-1:0] free_idx_s;

  // Priority encoder; scanning downward leaves the lowest invalid index last.
  always_comb begin
    free_idx_s = {IDX_W{1'b0}};
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      free_idx_s = vld[i] ? free_idx_s : IDX_W'(i);
    end
    replace = &vld;
    tgt_idx = replace ? victim_ptr : free_idx_s;
  end

endmodule

// File: rtl/ct_ifu_sfp_ctrl.sv
// SFP entry-array write scheduler: flush > update > alloc arbitration, victim
// replacement and a one-entry-per-cycle flush sweep, all writes registered.
module ct_ifu_sfp_ctrl
  import ct_ifu_sfp_pkg::*;
#(
  parameter int ENTRY_NUM = 8,
  parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 cp0_ifu_nsfe,
  input  logic                 sfp_vl_pred_en,
  input  logic                 sfp_alloc_req,
  input  logic                 sfp_alloc_type,
  input  logic [7:0]           sfp_alloc_hi_pc,
  input  logic [11:0]          sfp_alloc_pc,
  output logic                 sfp_alloc_ack,
  input  logic                 sfp_updt_req,
  input  logic [IDX_W-1:0]     sfp_updt_idx,
  input  logic                 sfp_updt_bar_vld,
  input  logic [11:0]          sfp_updt_bar_pc,
  input  logic [3:0]           sfp_updt_cnt_op,
  input  logic                 sfp_updt_type,
  output logic                 sfp_updt_ack,
  input  logic                 sfp_flush_req,
  output logic [ENTRY_NUM-1:0] sfp_entry_write_en,
  output logic [ENTRY_NUM-1:0] sfp_entry_clk_en,
  output logic                 sfp_entry_sf_pc_updt,
  output logic                 sfp_entry_bar_pc_updt,
  output logic                 sfp_entry_cnt_updt,
  output logic [24:0]          sfp_entry_write_data,
  output logic [ENTRY_NUM-1:0] sfp_entry_vld,
  output logic                 sfp_ctrl_busy
);

  localparam logic [ENTRY_NUM-1:0] ONE_HOT_BASE = {{(ENTRY_NUM-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'(ENTRY_NUM - 1);

  sfp_state_e           state_r, state_nxt_s;
  logic [IDX_W-1:0]     sweep_idx_r, sweep_idx_nxt_s;
  logic [IDX_W-1:0]     victim_ptr_r, victim_ptr_nxt_s;
  logic [ENTRY_NUM-1:0] vld_r, vld_nxt_s;
  logic [ENTRY_NUM-1:0] wen_r, wen_nxt_s;
  logic                 sf_updt_r, sf_updt_nxt_s;
  logic                 bar_updt_r, bar_updt_nxt_s;
  logic                 cnt_updt_r, cnt_updt_nxt_s;
  logic [24:0]          data_r, data_nxt_s;
  logic                 busy_r;
  logic                 sfp_en_s, alloc_ack_s, updt_ack_s;
  logic [IDX_W-1:0]     tgt_idx_s;
  logic                 replace_s;

  assign sfp_en_s = cp0_ifu_nsfe | sfp_vl_pred_en;

  ct_ifu_sfp_victim_sel #(
    .ENTRY_NUM (ENTRY_NUM),
    .IDX_W     (IDX_W)
  ) u_victim_sel (
    .vld        (vld_r),
    .victim_ptr (victim_ptr_r),
    .tgt_idx    (tgt_idx_s),
    .replace    (replace_s)
  );

  // Arbitration, next state and next registered write command.
  always_comb begin
    state_nxt_s      = state_r;
    sweep_idx_nxt_s  = sweep_idx_r;
    victim_ptr_nxt_s = victim_ptr_r;
    vld_nxt_s        = vld_r;
    wen_nxt_s        = {ENTRY_NUM{1'b0}};
    sf_updt_nxt_s    = 1'b0;
    bar_updt_nxt_s   = 1'b0;
    cnt_updt_nxt_s   = 1'b0;
    data_nxt_s       = 25'h0000000;
    alloc_ack_s      = 1'b0;
    updt_ack_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!sfp_en_s) begin
          vld_nxt_s = {ENTRY_NUM{1'b0}};
        end else if (sfp_flush_req) begin
          state_nxt_s     = ST_SWEEP;
          sweep_idx_nxt_s = {IDX_W{1'b0}};
          vld_nxt_s       = {ENTRY_NUM{1'b0}};
          wen_nxt_s       = ONE_HOT_BASE;
          sf_updt_nxt_s   = 1'b1;
          bar_updt_nxt_s  = 1'b1;
          cnt_updt_nxt_s  = 1'b1;
          data_nxt_s      = sfp_pack_data(1'b0, 8'h00, 12'h000, CNT_CLR);
        end else if (sfp_updt_req) begin
          updt_ack_s     = 1'b1;
          wen_nxt_s      = ONE_HOT_BASE << sfp_updt_idx;
          bar_updt_nxt_s = sfp_updt_bar_vld;
          cnt_updt_nxt_s = (sfp_updt_cnt_op != CNT_NONE);
          data_nxt_s     = sfp_pack_data(sfp_updt_type, 8'h00, sfp_updt_bar_pc, sfp_updt_cnt_op);
        end else if (sfp_alloc_req) begin
          // SET1 plus bar_pc=pc resets the counter and drops any stale barrier.
          alloc_ack_s            = 1'b1;
          wen_nxt_s              = ONE_HOT_BASE << tgt_idx_s;
          sf_updt_nxt_s          = 1'b1;
          bar_updt_nxt_s         = 1'b1;
          cnt_updt_nxt_s         = 1'b1;
          data_nxt_s             = sfp_pack_data(sfp_alloc_type, sfp_alloc_hi_pc, sfp_alloc_pc, CNT_SET1);
          vld_nxt_s[tgt_idx_s]   = 1'b1;
          victim_ptr_nxt_s       = replace_s ? victim_ptr_r + IDX_W'(1) : victim_ptr_r;
        end else begin
          vld_nxt_s = vld_r;
        end
      end
      ST_SWEEP: begin
        if (!sfp_en_s || (sweep_idx_r == LAST_IDX)) begin
          state_nxt_s      = ST_IDLE;
          sweep_idx_nxt_s  = {IDX_W{1'b0}};
          victim_ptr_nxt_s = {IDX_W{1'b0}};
          vld_nxt_s        = {ENTRY_NUM{1'b0}};
        end else begin
          sweep_idx_nxt_s = sweep_idx_r + IDX_W'(1);
          wen_nxt_s       = ONE_HOT_BASE << (sweep_idx_r + IDX_W'(1));
          sf_updt_nxt_s   = 1'b1;
          bar_updt_nxt_s  = 1'b1;
          cnt_updt_nxt_s  = 1'b1;
          data_nxt_s      = sfp_pack_data(1'b0, 8'h00, 12'h000, CNT_CLR);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, tracking and registered entry-array command.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_r      <= ST_IDLE;
      sweep_idx_r  <= {IDX_W{1'b0}};
      victim_ptr_r <= {IDX_W{1'b0}};
      vld_r        <= {ENTRY_NUM{1'b0}};
      wen_r        <= {ENTRY_NUM{1'b0}};
      sf_updt_r    <= 1'b0;
      bar_updt_r   <= 1'b0;
      cnt_updt_r   <= 1'b0;
      data_r       <= 25'h0000000;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      sweep_idx_r  <= sweep_idx_nxt_s;
      victim_ptr_r <= victim_ptr_nxt_s;
      vld_r        <= vld_nxt_s;
      wen_r        <= wen_nxt_s;
      sf_updt_r    <= sf_updt_nxt_s;
      bar_updt_r   <= bar_updt_nxt_s;
      cnt_updt_r   <= cnt_updt_nxt_s;
      data_r       <= data_nxt_s;
      busy_r       <= (state_nxt_s == ST_SWEEP);
    end
  end

  assign sfp_alloc_ack         = alloc_ack_s;
  assign sfp_updt_ack          = updt_ack_s;
  assign sfp_entry_write_en    = wen_r;
  assign sfp_entry_clk_en      = wen_r;
  assign sfp_entry_sf_pc_updt  = sf_updt_r;
  assign sfp_entry_bar_pc_updt = bar_updt_r;
  assign sfp_entry_cnt_updt    = cnt_updt_r;
  assign sfp_entry_write_data  = data_r;
  assign sfp_entry_vld         = vld_r;
  assign sfp_ctrl_busy         = busy_r;

endmodule

// File: tb/tb_ct_ifu_sfp_ctrl.sv
// Directed self-checking bench for ct_ifu_sfp_ctrl with ENTRY_NUM=8.
module tb_ct_ifu_sfp_ctrl;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  logic        cp0_ifu_nsfe, sfp_vl_pred_en;
  logic        sfp_alloc_req, sfp_alloc_type;
  logic [7:0]  sfp_alloc_hi_pc;
  logic [11:0] sfp_alloc_pc;
  logic        sfp_alloc_ack;
  logic        sfp_updt_req;
  logic [2:0]  sfp_updt_idx;
  logic        sfp_updt_bar_vld;
  logic [11:0] sfp_updt_bar_pc;
  logic [3:0]  sfp_updt_cnt_op;
  logic        sfp_updt_type;
  logic        sfp_updt_ack;
  logic        sfp_flush_req;
  logic [7:0]  sfp_entry_write_en, sfp_entry_clk_en, sfp_entry_vld;
  logic        sfp_entry_sf_pc_updt, sfp_entry_bar_pc_updt, sfp_entry_cnt_updt;
  logic [24:0] sfp_entry_write_data;
  logic        sfp_ctrl_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_ifu_sfp_ctrl #(.ENTRY_NUM(8)) dut (
    .forever_cpuclk        (forever_cpuclk),
    .cpurst                (cpurst),
    .cp0_ifu_nsfe          (cp0_ifu_nsfe),
    .sfp_vl_pred_en        (sfp_vl_pred_en),
    .sfp_alloc_req         (sfp_alloc_req),
    .sfp_alloc_type        (sfp_alloc_type),
    .sfp_alloc_hi_pc       (sfp_alloc_hi_pc),
    .sfp_alloc_pc          (sfp_alloc_pc),
    .sfp_alloc_ack         (sfp_alloc_ack),
    .sfp_updt_req          (sfp_updt_req),
    .sfp_updt_idx          (sfp_updt_idx),
    .sfp_updt_bar_vld      (sfp_updt_bar_vld),
    .sfp_updt_bar_pc       (sfp_updt_bar_pc),
    .sfp_updt_cnt_op       (sfp_updt_cnt_op),
    .sfp_updt_type         (sfp_updt_type),
    .sfp_updt_ack          (sfp_updt_ack),
    .sfp_flush_req         (sfp_flush_req),
    .sfp_entry_write_en    (sfp_entry_write_en),
    .sfp_entry_clk_en      (sfp_entry_clk_en),
    .sfp_entry_sf_pc_updt  (sfp_entry_sf_pc_updt),
    .sfp_entry_bar_pc_updt (sfp_entry_bar_pc_updt),
    .sfp_entry_cnt_updt    (sfp_entry_cnt_updt),
    .sfp_entry_write_data  (sfp_entry_write_data),
    .sfp_entry_vld         (sfp_entry_vld),
    .sfp_ctrl_busy         (sfp_ctrl_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  initial begin
    logic [24:0] exp_d;
    cpurst = 1'b1; cp0_ifu_nsfe = 1'b1; sfp_vl_pred_en = 1'b0;
    sfp_alloc_req = 1'b0; sfp_alloc_type = 1'b0; sfp_alloc_hi_pc = 8'h00; sfp_alloc_pc = 12'h000;
    sfp_updt_req = 1'b0; sfp_updt_idx = 3'd0; sfp_updt_bar_vld = 1'b0; sfp_updt_bar_pc = 12'h000;
    sfp_updt_cnt_op = 4'b0000; sfp_updt_type = 1'b0; sfp_flush_req = 1'b0;
    tick(); tick();
    cpurst = 1'b0;
    chk("rst_wen", 32'(sfp_entry_write_en), 32'h0);
    chk("rst_data", 32'(sfp_entry_write_data), 32'h0);
    chk("rst_vld", 32'(sfp_entry_vld), 32'h0);
    chk("rst_busy", 32'(sfp_ctrl_busy), 32'h0);

    // Fill the table: entries 0..7 in order
    for (int i = 0; i < 8; i++) begin
      sfp_alloc_req = 1'b1; sfp_alloc_type = i[0];
      sfp_alloc_hi_pc = 8'(32'h10 + i); sfp_alloc_pc = 12'(32'h100 + i);
      exp_d = {sfp_alloc_type, sfp_alloc_hi_pc, sfp_alloc_pc, 4'b0010};
      #1 chk("fill_ack", 32'(sfp_alloc_ack), 32'h1);
      chk("fill_uack", 32'(sfp_updt_ack), 32'h0);
      tick();
      chk("fill_wen", 32'(sfp_entry_write_en), 32'h1 << i);
      chk("fill_cken", 32'(sfp_entry_clk_en), 32'h1 << i);
      chk("fill_data", 32'(sfp_entry_write_data), 32'(exp_d));
      chk("fill_bits", {29'h0, sfp_entry_sf_pc_updt, sfp_entry_bar_pc_updt, sfp_entry_cnt_updt}, 32'h7);
      chk("fill_vld", 32'(sfp_entry_vld), (32'h2 << i) - 32'h1);
    end
    sfp_alloc_req = 1'b0;
    #1 chk("idle_ack", 32'(sfp_alloc_ack), 32'h0);
    tick();
    chk("pulse_wen", 32'(sfp_entry_write_en), 32'h0);
    chk("pulse_cnt", 32'(sfp_entry_cnt_updt), 32'h0);

    // Full table: victims 0 then 1
    sfp_alloc_req = 1'b1; sfp_alloc_type = 1'b1; sfp_alloc_hi_pc = 8'h18; sfp_alloc_pc = 12'h108;
    tick();
    chk("repl0_wen", 32'(sfp_entry_write_en), 32'h01);
    chk("repl0_data", 32'(sfp_entry_write_data), 32'h1181082);
    sfp_alloc_type = 1'b0; sfp_alloc_hi_pc = 8'h19; sfp_alloc_pc = 12'h109;
    tick();
    chk("repl1_wen", 32'(sfp_entry_write_en), 32'h02);
    chk("repl_vld", 32'(sfp_entry_vld), 32'hFF);

    // Update beats alloc in the same cycle
    sfp_alloc_hi_pc = 8'h1A; sfp_alloc_pc = 12'h10A;
    sfp_updt_req = 1'b1; sfp_updt_idx = 3'd3; sfp_updt_cnt_op = 4'b0100;
    sfp_updt_bar_vld = 1'b1; sfp_updt_bar_pc = 12'hABC; sfp_updt_type = 1'b1;
    #1 chk("coll_uack", 32'(sfp_updt_ack), 32'h1);
    chk("coll_aack", 32'(sfp_alloc_ack), 32'h0);
    tick();
    sfp_updt_req = 1'b0;
    chk("updt_wen", 32'(sfp_entry_write_en), 32'h08);
    chk("updt_bits", {29'h0, sfp_entry_sf_pc_updt, sfp_entry_bar_pc_updt, sfp_entry_cnt_updt}, 32'h3);
    chk("updt_data", 32'(sfp_entry_write_data), 32'h100ABC4);
    #1 chk("retry_aack", 32'(sfp_alloc_ack), 32'h1);
    tick();
    sfp_alloc_req = 1'b0;
    chk("retry_wen", 32'(sfp_entry_write_en), 32'h04);
    chk("retry_data", 32'(sfp_entry_write_data), 32'h01A10A2);

    // Update without barrier, decrement op
    sfp_updt_req = 1'b1; sfp_updt_idx = 3'd6; sfp_updt_cnt_op = 4'b0001;
    sfp_updt_bar_vld = 1'b0; sfp_updt_bar_pc = 12'h123; sfp_updt_type = 1'b0;
    tick();
    sfp_updt_req = 1'b0;
    chk("updt2_wen", 32'(sfp_entry_write_en), 32'h40);
    chk("updt2_bits", {29'h0, sfp_entry_sf_pc_updt, sfp_entry_bar_pc_updt, sfp_entry_cnt_updt}, 32'h1);
    chk("updt2_data", 32'(sfp_entry_write_data), 32'h0001231);

    // Flush with requests pending
    sfp_flush_req = 1'b1; sfp_alloc_req = 1'b1;
    sfp_updt_req = 1'b1; sfp_updt_idx = 3'd5; sfp_updt_cnt_op = 4'b0100;
    sfp_updt_bar_vld = 1'b0; sfp_updt_bar_pc = 12'h000; sfp_updt_type = 1'b0;
    #1 chk("fl_uack", 32'(sfp_updt_ack), 32'h0);
    chk("fl_aack", 32'(sfp_alloc_ack), 32'h0);
    tick();
    sfp_flush_req = 1'b0;
    chk("fl_bits", {29'h0, sfp_entry_sf_pc_updt, sfp_entry_bar_pc_updt, sfp_entry_cnt_updt}, 32'h7);
    for (int i = 0; i < 8; i++) begin
      chk("sw_busy", 32'(sfp_ctrl_busy), 32'h1);
      chk("sw_wen", 32'(sfp_entry_write_en), 32'h1 << i);
      chk("sw_data", 32'(sfp_entry_write_data), 32'h0000008);
      chk("sw_vld", 32'(sfp_entry_vld), 32'h0);
      #1 chk("sw_acks", {30'h0, sfp_updt_ack, sfp_alloc_ack}, 32'h0);
      tick();
    end
    chk("swend_busy", 32'(sfp_ctrl_busy), 32'h0);
    chk("swend_wen", 32'(sfp_entry_write_en), 32'h0);
    #1 chk("post_uack", 32'(sfp_updt_ack), 32'h1);
    chk("post_aack", 32'(sfp_alloc_ack), 32'h0);
    tick();
    sfp_updt_req = 1'b0;
    chk("post_uwen", 32'(sfp_entry_write_en), 32'h20);
    chk("post_udata", 32'(sfp_entry_write_data), 32'h0000004);
    #1 chk("post_aack2", 32'(sfp_alloc_ack), 32'h1);
    tick();
    sfp_alloc_req = 1'b0;
    chk("post_awen", 32'(sfp_entry_write_en), 32'h01);
    chk("post_vld", 32'(sfp_entry_vld), 32'h01);

    // Disable during sweep at entry 3
    sfp_flush_req = 1'b1;
    tick();
    sfp_flush_req = 1'b0;
    tick(); tick(); tick();
    chk("dis_wen3", 32'(sfp_entry_write_en), 32'h08);
    cp0_ifu_nsfe = 1'b0; sfp_vl_pred_en = 1'b0; sfp_alloc_req = 1'b1;
    #1 chk("dis_aack", 32'(sfp_alloc_ack), 32'h0);
    tick();
    chk("dis_busy", 32'(sfp_ctrl_busy), 32'h0);
    chk("dis_wen", 32'(sfp_entry_write_en), 32'h0);
    chk("dis_vld", 32'(sfp_entry_vld), 32'h0);
    #1 chk("dis_aack2", 32'(sfp_alloc_ack), 32'h0);
    tick();
    chk("dis_wen2", 32'(sfp_entry_write_en), 32'h0);
    sfp_flush_req = 1'b1;
    tick();
    sfp_flush_req = 1'b0;
    chk("dis_flush_busy", 32'(sfp_ctrl_busy), 32'h0);
    chk("dis_flush_wen", 32'(sfp_entry_write_en), 32'h0);
    sfp_vl_pred_en = 1'b1;
    #1 chk("vl_en_aack", 32'(sfp_alloc_ack), 32'h1);
    tick();
    sfp_alloc_req = 1'b0;
    chk("vl_en_wen", 32'(sfp_entry_write_en), 32'h01);
    chk("vl_en_vld", 32'(sfp_entry_vld), 32'h01);

    // Reset mid-sweep
    sfp_flush_req = 1'b1;
    tick();
    sfp_flush_req = 1'b0;
    tick(); tick();
    chk("pre_rst_wen", 32'(sfp_entry_write_en), 32'h04);
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    chk("mrst_wen", 32'(sfp_entry_write_en), 32'h0);
    chk("mrst_cken", 32'(sfp_entry_clk_en), 32'h0);
    chk("mrst_bits", {29'h0, sfp_entry_sf_pc_updt, sfp_entry_bar_pc_updt, sfp_entry_cnt_updt}, 32'h0);
    chk("mrst_data", 32'(sfp_entry_write_data), 32'h0);
    chk("mrst_busy", 32'(sfp_ctrl_busy), 32'h0);
    chk("mrst_vld", 32'(sfp_entry_vld), 32'h0);
    tick();
    chk("mrst_wen2", 32'(sfp_entry_write_en), 32'h0);
    chk("mrst_busy2", 32'(sfp_ctrl_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ct_ifu_sfp_ctrl.md
# ct_ifu_sfp_ctrl

Write scheduler and replacement controller for the IFU store-forward predictor (SFP) entry array. It arbitrates between allocation requests (new store/load PC pairs from retire training) and update requests (barrier PC and confidence-counter operations on existing entries). It picks the target entry through valid tracking plus a round-robin victim pointer, and sequences a full-table flush sweep. It drives the per-entry write enables, clock enables, update bits and the shared 25-bit write-data bus of the entry array.

## Interface
- ENTRY_NUM, 8: number of SFP entries (power of 2, ≥2)
- IDX_W, $clog2(ENTRY_NUM): entry index width
- forever_cpuclk  in  1  free-running core clock
- cpurst  in  1  reset, synchronous, active-high
- cp0_ifu_nsfe  in  1  SFP enable (non-speculative forwarding)
- sfp_vl_pred_en  in  1  SFP enable (vector-load prediction); `sfp_en = cp0_ifu_nsfe | sfp_vl_pred_en`
- sfp_alloc_req  in  1  allocation request, held until ack
- sfp_alloc_type  in  1  entry type, goes to data[24]
- sfp_alloc_hi_pc  in  8  high PC tag, goes to data[23:16]
- sfp_alloc_pc  in  12  store PC[15:4], goes to data[15:4]
- sfp_alloc_ack  out  1  allocation accepted this cycle
- sfp_updt_req  in  1  update request, held until ack
- sfp_updt_idx  in  IDX_W  target entry
- sfp_updt_bar_vld  in  1  write barrier PC
- sfp_updt_bar_pc  in  12  barrier PC, goes to data[15:4]
- sfp_updt_cnt_op  in  4  one-hot counter op (1000 clr, 0100 inc, 0010 set1, 0001 dec, 0000 none), goes to data[3:0]
- sfp_updt_type  in  1  current entry type, goes to data[24]
- sfp_updt_ack  out  1  update accepted this cycle
- sfp_flush_req  in  1  single-cycle pulse, flush whole table
- sfp_entry_write_en  out  ENTRY_NUM  one-hot write enable
- sfp_entry_clk_en  out  ENTRY_NUM  per-entry gated-clock enable
- sfp_entry_sf_pc_updt  out  1  update type/hi_pc/sf_pc fields
- sfp_entry_bar_pc_updt  out  1  update bar_pc field
- sfp_entry_cnt_updt  out  1  update counter
- sfp_entry_write_data  out  25  shared write data
- sfp_entry_vld  out  ENTRY_NUM  controller valid bits
- sfp_ctrl_busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, SWEEP. Reset: IDLE, all outputs 0, valid bits 0, victim pointer 0, sweep index 0.
- IDLE arbitration, each cycle: flush > update > alloc. At most one ack per cycle. Acks are combinational from requests, state and sfp_en.
- When sfp_en=0: no ack, no write. A pending flush is dropped and all valid bits clear in the next cycle.
- Update accepted: write_en/clk_en one-hot at sfp_updt_idx; bar_pc_updt=sfp_updt_bar_vld; cnt_updt=(cnt_op≠0); sf_pc_updt=0; data={sfp_updt_type,8'b0,bar_pc,cnt_op}. Valid bit unchanged. An update to an invalid index is still performed.
- Alloc accepted: target = lowest-index invalid entry, else victim pointer. Drives sf_pc_updt=1, cnt_updt=1, bar_pc_updt=1 with data={type,hi_pc,pc,4'b0010}. This sets counter 01 and bar_pc=pc, clearing the stale barrier. Target valid bit set.
- Victim pointer increments (mod ENTRY_NUM) only when an alloc replaces a valid entry.
- Alloc and update in the same cycle: update wins, alloc_ack=0. Requester holds, retries next cycle.
- Flush in IDLE: enter SWEEP, clear all valid bits immediately, pending reqs not acked. SWEEP writes entry sweep_idx each cycle with all three updt bits = 1 and data = 25'h0000008, i.e. cnt op 1000, all fields 0. After index ENTRY_NUM-1 it returns to IDLE, sweep index to 0, victim pointer to 0.
- sfp_en drop during SWEEP: abort to IDLE next cycle. Valid bits stay 0.
- Flush during SWEEP: ignored.

## Timing
- Request accepted in cycle N → all sfp_entry_* outputs registered, valid in cycle N+1 for exactly one cycle, then 0.
- Entry state changes at the edge ending N+1. Valid bit and victim pointer update at the edge ending N.
- Back-to-back acks are allowed every cycle in IDLE: throughput 1 write/cycle.
- Flush pulse in N → sweep writes in N+1 … N+ENTRY_NUM. busy=1 from N+1 through N+ENTRY_NUM. First ack possible in N+ENTRY_NUM+1.
- Synchronous reset takes priority in any state. Outputs are 0 in the cycle following the reset assertion edge.

## Structure
- Shared package ct_ifu_sfp_pkg: cnt op one-hot constants (CNT_CLR/INC/SET1/DEC), data field offsets ([24] type, [23:16] hi_pc, [15:4] pc, [3:0] op), FSM state enum.
- One sub-module: ct_ifu_sfp_victim_sel. Combinational lowest-invalid priority encoder plus round-robin pointer fallback; outputs target index and a replace flag.

## Test plan
- Reset, then 8 allocs with ENTRY_NUM=8 and pc=0x100+i → entries 0..7 written in order with data[3:0]=0010; victim pointer stays 0; vld=0xFF.
- Table full, 2 more allocs → entries 0 then 1 replaced; victim pointer ends at 2.
- Alloc and update (idx=3, cnt_op=0100, bar_vld=1, bar_pc=0xABC) in the same cycle → only updt_ack; next cycle write_en=0x08, bar_pc_updt=1, cnt_updt=1, sf_pc_updt=0, data[15:0]=0xABC4; alloc acked the following cycle.
- Flush pulse with table full → vld=0 at once; write_en walks 0x01…0x80 over 8 cycles with data 0x0000008; busy for 8 cycles; requests held and not acked.
- Flush, then cp0_ifu_nsfe=sfp_vl_pred_en=0 at sweep entry 3 → IDLE next cycle; no further write_en; acks stay 0 while disabled.
- cpurst asserted mid-sweep → next cycle all outputs 0, IDLE, vld=0.
